// File: rtl/stepdir_monitor.sv
// Step/dir monitor: rebuilds position from step rises and
// flags pulse and dir timing that breaks steptime/dirtime.
module stepdir_monitor #(
  parameter int W  = 20,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          dir,
  input  logic [TW-1:0] steptime,
  input  logic [TW-1:0] dirtime,
  input  logic          latch,
  input  logic          clr_err,
  output logic [W-1:0]  pos,
  output logic [W-1:0]  pos_latched,
  output logic          err_high,
  output logic          err_low,
  output logic          err_setup,
  output logic          err_hold,
  output logic          err_any
);

  localparam logic [TW-1:0] SAT  = '1;
  localparam logic [TW-1:0] CONE = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  PONE = {{(W-1){1'b0}}, 1'b1};

  logic          sp;
  logic          dp;
  logic [TW-1:0] hi_cnt;
  logic [TW-1:0] lo_cnt;
  logic [TW-1:0] dir_cnt;

  logic          rise;
  logic          fall;
  logic          dchg;
  logic [TW-1:0] dage;
  logic          v_low;
  logic          v_high;
  logic          v_setup;
  logic          v_hold;
  logic [W-1:0]  pos_nxt;

  function automatic logic [TW-1:0] sat_inc(
    input logic [TW-1:0] v
  );
    return (v == SAT) ? v : v + CONE;
  endfunction

  always_comb begin
    rise    = step & ~sp;
    fall    = ~step & sp;
    dchg    = dir ^ dp;
    dage    = dchg ? '0 : dir_cnt;
    v_low   = rise & (lo_cnt < steptime);
    v_setup = rise & (dage < dirtime);
    v_high  = fall & (hi_cnt < steptime);
    // a dir edge landing on the rise is a setup fault only
    v_hold  = dchg & ~rise &
              (sp | (lo_cnt < dirtime));
    pos_nxt = pos;
    if (rise)
      pos_nxt = dir ? pos + PONE : pos - PONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp          <= 1'b0;
      dp          <= 1'b0;
      hi_cnt      <= SAT;
      lo_cnt      <= SAT;
      dir_cnt     <= SAT;
      pos         <= '0;
      pos_latched <= '0;
      err_high    <= 1'b0;
      err_low     <= 1'b0;
      err_setup   <= 1'b0;
      err_hold    <= 1'b0;
      err_any     <= 1'b0;
    end else begin
      sp      <= step;
      dp      <= dir;
      hi_cnt  <= step ? sat_inc(hi_cnt) : '0;
      lo_cnt  <= step ? '0 : sat_inc(lo_cnt);
      dir_cnt <= dchg ? CONE : sat_inc(dir_cnt);
      pos     <= pos_nxt;
      if (latch)
        pos_latched <= pos_nxt;
      err_high  <= v_high  | (err_high  & ~clr_err);
      err_low   <= v_low   | (err_low   & ~clr_err);
      err_setup <= v_setup | (err_setup & ~clr_err);
      err_hold  <= v_hold  | (err_hold  & ~clr_err);
      err_any   <= err_high | err_low |
                   err_setup | err_hold;
    end
  end

endmodule

// File: tb/tb_stepdir_monitor.sv
// Scoreboard bench for stepdir_monitor: per-cycle position
// model plus directed timing-violation scenarios.
module tb_stepdir_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step = 1'b0;
  logic        dir = 1'b0;
  logic [7:0]  steptime = 8'd4;
  logic [7:0]  dirtime = 8'd4;
  logic        latch = 1'b0;
  logic        clr_err = 1'b0;
  logic [19:0] pos;
  logic [19:0] pos_latched;
  logic        err_high;
  logic        err_low;
  logic        err_setup;
  logic        err_hold;
  logic        err_any;

  int n_chk = 0;
  int n_pass = 0;

  logic        msp;
  logic [19:0] mpos;
  logic [19:0] expq[$];

  stepdir_monitor #(.W(20), .TW(8)) dut (
    .clk(clk),
    .reset(reset),
    .step(step),
    .dir(dir),
    .steptime(steptime),
    .dirtime(dirtime),
    .latch(latch),
    .clr_err(clr_err),
    .pos(pos),
    .pos_latched(pos_latched),
    .err_high(err_high),
    .err_low(err_low),
    .err_setup(err_setup),
    .err_hold(err_hold),
    .err_any(err_any)
  );

  always #5 clk = ~clk;

  // drive one sample, push the expected pos, advance one edge
  task automatic tick(input logic s, input logic d);
    step = s;
    dir  = d;
    if (reset) begin
      msp  = 1'b0;
      mpos = 20'd0;
    end else begin
      if (s && !msp)
        mpos = d ? mpos + 20'd1 : mpos - 20'd1;
      msp = s;
    end
    expq.push_back(mpos);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic s, input logic d, input int n);
    for (int i = 0; i < n; i++) tick(s, d);
  endtask

  task automatic do_reset(input logic s, input logic d);
    reset = 1'b1;
    tick(s, d);
    reset = 1'b0;
    expq.delete();
  endtask

  task automatic clear_flags(input logic d);
    clr_err = 1'b1;
    tick(1'b0, d);
    clr_err = 1'b0;
    tick(1'b0, d);
    expq.delete();
  endtask

  task automatic test_reset;
    logic [4:0] f;
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
    expq.delete();
    f = {err_high, err_low, err_setup, err_hold, err_any};
    n_chk++;
    if (pos !== 20'd0)
      $display("FAIL reset_pos: got %h want 00000", pos);
    else n_pass++;
    n_chk++;
    if (pos_latched !== 20'd0)
      $display("FAIL reset_lat: got %h want 00000", pos_latched);
    else n_pass++;
    n_chk++;
    if (f !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", f);
    else n_pass++;
  endtask

  task automatic test_legal;
    logic [1:0]  stim[$];
    logic [19:0] e;
    logic [4:0]  f;
    int          bad;
    steptime = 8'd4;
    dirtime  = 8'd4;
    do_reset(1'b0, 1'b0);
    for (int p = 0; p < 10; p++)
      for (int j = 0; j < 10; j++)
        stim.push_back({j >= 5, 1'b1});
    for (int j = 0; j < 5; j++) stim.push_back(2'b01);
    for (int j = 0; j < 6; j++) stim.push_back(2'b00);
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 10; j++)
        stim.push_back({j < 5, 1'b0});
    bad = 0;
    foreach (stim[k]) begin
      tick(stim[k][1], stim[k][0]);
      e = expq.pop_front();
      n_chk++;
      if (pos !== e) begin
        if (bad < 5)
          $display("FAIL legal_pos[%0d]: got %h want %h",
                   k, pos, e);
        bad++;
      end else n_pass++;
    end
    f = {err_high, err_low, err_setup, err_hold, err_any};
    n_chk++;
    if (pos !== 20'd7)
      $display("FAIL legal_final: got %h want 00007", pos);
    else n_pass++;
    n_chk++;
    if (f !== 5'b0)
      $display("FAIL legal_flags: got %b want 00000", f);
    else n_pass++;
  endtask

  task automatic test_wrap;
    logic [4:0] f;
    steptime = 8'd4;
    dirtime  = 8'd4;
    do_reset(1'b0, 1'b0);
    run(1'b0, 1'b0, 5);
    latch = 1'b1;
    tick(1'b1, 1'b0);
    latch = 1'b0;
    n_chk++;
    if (pos !== 20'hFFFFF)
      $display("FAIL wrap_down: got %h want fffff", pos);
    else n_pass++;
    n_chk++;
    if (pos_latched !== 20'hFFFFF)
      $display("FAIL wrap_lat1: got %h want fffff", pos_latched);
    else n_pass++;
    run(1'b1, 1'b0, 4);
    run(1'b0, 1'b0, 5);
    run(1'b0, 1'b1, 5);
    latch = 1'b1;
    tick(1'b1, 1'b1);
    latch = 1'b0;
    n_chk++;
    if (pos !== 20'd0)
      $display("FAIL wrap_up: got %h want 00000", pos);
    else n_pass++;
    n_chk++;
    if (pos_latched !== 20'd0)
      $display("FAIL wrap_lat2: got %h want 00000", pos_latched);
    else n_pass++;
    run(1'b1, 1'b1, 4);
    run(1'b0, 1'b1, 5);
    f = {err_high, err_low, err_setup, err_hold, err_any};
    n_chk++;
    if (f !== 5'b0)
      $display("FAIL wrap_flags: got %b want 00000", f);
    else n_pass++;
    expq.delete();
  endtask

  task automatic test_short_pulse;
    steptime = 8'd4;
    dirtime  = 8'd4;
    do_reset(1'b0, 1'b0);
    run(1'b0, 1'b0, 5);
    run(1'b1, 1'b0, 3);
    tick(1'b0, 1'b0);
    n_chk++;
    if (err_high !== 1'b1 || err_any !== 1'b0)
      $display("FAIL short_high: got %b%b want 10",
               err_high, err_any);
    else n_pass++;
    tick(1'b0, 1'b0);
    n_chk++;
    if (err_any !== 1'b1)
      $display("FAIL short_any: got %b want 1", err_any);
    else n_pass++;
    clr_err = 1'b1;
    tick(1'b0, 1'b0);
    clr_err = 1'b0;
    n_chk++;
    if (err_high !== 1'b0)
      $display("FAIL short_clr: got %b want 0", err_high);
    else n_pass++;
    tick(1'b0, 1'b0);
    n_chk++;
    if (err_any !== 1'b0)
      $display("FAIL short_clr_any: got %b want 0", err_any);
    else n_pass++;
    run(1'b0, 1'b0, 2);
    run(1'b1, 1'b0, 2);
    clr_err = 1'b1;
    tick(1'b0, 1'b0);
    clr_err = 1'b0;
    n_chk++;
    if (err_high !== 1'b1 || err_low !== 1'b0)
      $display("FAIL short_set_wins: got %b%b want 10",
               err_high, err_low);
    else n_pass++;
    expq.delete();
  endtask

  task automatic test_dir_timing;
    logic [4:0] f;
    steptime = 8'd4;
    dirtime  = 8'd4;
    do_reset(1'b0, 1'b0);
    run(1'b0, 1'b0, 5);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    n_chk++;
    if (err_setup !== 1'b1 || err_hold !== 1'b0)
      $display("FAIL dir_setup2: got %b%b want 10",
               err_setup, err_hold);
    else n_pass++;
    run(1'b1, 1'b1, 4);
    run(1'b0, 1'b1, 5);
    clear_flags(1'b1);
    f = {err_high, err_low, err_setup, err_hold, err_any};
    n_chk++;
    if (f !== 5'b0)
      $display("FAIL dir_clear: got %b want 00000", f);
    else n_pass++;
    tick(1'b1, 1'b0);
    n_chk++;
    if (err_setup !== 1'b1 || err_hold !== 1'b0)
      $display("FAIL dir_on_rise: got %b%b want 10",
               err_setup, err_hold);
    else n_pass++;
    run(1'b1, 1'b0, 4);
    run(1'b0, 1'b0, 5);
    clear_flags(1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    n_chk++;
    if (err_hold !== 1'b1 || err_setup !== 1'b0)
      $display("FAIL dir_while_high: got %b%b want 10",
               err_hold, err_setup);
    else n_pass++;
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 5);
    clear_flags(1'b1);
    run(1'b1, 1'b1, 5);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    f = {err_high, err_low, err_setup, err_hold, 1'b0};
    n_chk++;
    if (f !== 5'b00010)
      $display("FAIL dir_after_fall: got %b want 00010", f);
    else n_pass++;
    clear_flags(1'b0);
  endtask

  task automatic test_back_to_back;
    logic signed [4:0] vel;
    logic [4:0]  mag;
    logic        gs;
    logic        gd;
    logic        s;
    logic [19:0] e;
    logic [4:0]  f;
    int          acc;
    int          bad;
    steptime = 8'd1;
    dirtime  = 8'd0;
    do_reset(1'b0, 1'b0);
    acc = 0;
    gs  = 1'b0;
    gd  = 1'b0;
    bad = 0;
    for (int seg = 0; seg < 50; seg++) begin
      vel = seg[0] ? 5'sh18 : 5'sh08;
      mag = vel[4] ? 5'(-vel) : 5'(vel);
      for (int c = 0; c < 8; c++) begin
        if (gs) begin
          s = 1'b0;
        end else begin
          acc = acc + int'(mag);
          s = (acc >= 16);
          if (s) acc = acc - 16;
        end
        if (!gs) gd = ~vel[4];
        gs = s;
        tick(s, gd);
        e = expq.pop_front();
        n_chk++;
        if (pos !== e) begin
          if (bad < 5)
            $display("FAIL b2b_pos[%0d]: got %h want %h",
                     seg * 8 + c, pos, e);
          bad++;
        end else n_pass++;
      end
    end
    run(1'b0, gd, 2);
    f = {err_high, err_low, err_setup, err_hold, err_any};
    n_chk++;
    if (f !== 5'b0)
      $display("FAIL b2b_flags: got %b want 00000", f);
    else n_pass++;
    expq.delete();
  endtask

  task automatic test_reset_mid;
    logic [4:0] f;
    steptime = 8'd4;
    dirtime  = 8'd4;
    do_reset(1'b0, 1'b1);
    run(1'b0, 1'b1, 5);
    for (int p = 0; p < 4; p++) begin
      run(1'b1, 1'b1, 5);
      run(1'b0, 1'b1, 5);
    end
    latch = 1'b1;
    tick(1'b1, 1'b1);
    latch = 1'b0;
    tick(1'b1, 1'b1);
    n_chk++;
    if (pos !== 20'd5 || pos_latched !== 20'd5)
      $display("FAIL mid_pre: got %h/%h want 00005/00005",
               pos, pos_latched);
    else n_pass++;
    reset   = 1'b1;
    latch   = 1'b1;
    clr_err = 1'b1;
    tick(1'b1, 1'b1);
    reset   = 1'b0;
    latch   = 1'b0;
    clr_err = 1'b0;
    f = {err_high, err_low, err_setup, err_hold, err_any};
    n_chk++;
    if (pos !== 20'd0 || pos_latched !== 20'd0 || f !== 5'b0)
      $display("FAIL mid_reset: got %h/%h/%b want 0/0/0",
               pos, pos_latched, f);
    else n_pass++;
    // step still high after release reads as a rise (sp was 0),
    // and dir=1 against the reset dp=0 is a dir edge on that rise
    tick(1'b1, 1'b1);
    n_chk++;
    if (pos !== 20'd1 || err_setup !== 1'b1 || err_low !== 1'b0)
      $display("FAIL mid_rise: got %h/%b%b want 00001/10",
               pos, err_setup, err_low);
    else n_pass++;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    n_chk++;
    if (err_low !== 1'b1 || pos !== 20'd2 || err_high !== 1'b0)
      $display("FAIL mid_low: got %b/%h/%b want 1/00002/0",
               err_low, pos, err_high);
    else n_pass++;
    expq.delete();
  endtask

  initial begin
    msp  = 1'b0;
    mpos = 20'd0;
    test_reset();
    test_legal();
    test_wrap();
    test_short_pulse();
    test_dir_timing();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
